// File: rtl/set_pulse_sequencer_if.sv
// Request/response bundle between the control FSM (master) and the set-pulse sequencer (slave).
// sn_out and ck_en run onward to the flop bank's async-set pins and clock gate.
interface set_pulse_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic [WIDTH-1:0] req_mask;
    logic             req_ready;
    logic [WIDTH-1:0] sn_out;
    logic             ck_en;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_mask,
        input  req_ready, sn_out, ck_en, done, err
    );

    modport slave (
        input  req_valid, req_mask,
        output req_ready, sn_out, ck_en, done, err
    );
endinterface

// File: rtl/set_pulse_sequencer.sv
// Generates registered active-low set pulses for a flop bank. The bank clock is gated
// one cycle before SN falls and stays gated for the recovery window after SN rises.
module set_pulse_sequencer #(
    parameter int WIDTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int REC_CYC   = 2,
    parameter int CNT_W     = 4
) (
    input logic                  ck_i,
    input logic                  rst_i,
    set_pulse_sequencer_if.slave bus
);
    localparam int P_EFF = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
    localparam int R_EFF = (REC_CYC < 1) ? 1 : REC_CYC;
    localparam logic [CNT_W-1:0] P_LOAD = CNT_W'(P_EFF - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(R_EFF - 1);

    typedef enum logic [1:0] {IDLE, GATE, ASSERT, RECOVER} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] sn_q;
    logic             ck_en_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic             from_rst_q;

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q    <= RECOVER;
            cnt_q      <= R_LOAD;
            mask_q     <= '0;
            sn_q       <= '1;
            ck_en_q    <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            from_rst_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (|bus.req_mask) begin
                            mask_q  <= bus.req_mask;
                            state_q <= GATE;
                            ck_en_q <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                GATE: begin
                    state_q <= ASSERT;
                    sn_q    <= ~mask_q;
                    cnt_q   <= P_LOAD;
                end
                ASSERT: begin
                    if (cnt_q == '0) begin
                        state_q <= RECOVER;
                        sn_q    <= '1;
                        cnt_q   <= R_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt_q == '0) begin
                        // Leaving the post-reset recovery is not a completed request.
                        state_q    <= IDLE;
                        ck_en_q    <= 1'b1;
                        ready_q    <= 1'b1;
                        done_q     <= ~from_rst_q;
                        from_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= RECOVER;
                    sn_q    <= '1;
                    ck_en_q <= 1'b0;
                    ready_q <= 1'b0;
                    cnt_q   <= R_LOAD;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.sn_out    = sn_q;
    assign bus.ck_en     = ck_en_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
